// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined adder/subtractor.
//   mode_e      : operation select encoding carried on the 'sub' input.
//   calc_stages : number of pipeline stages for a given WIDTH and SEG.
//   seg_fits    : legality of a WIDTH/SEG pair, used for elaboration checks.
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    function automatic int calc_stages(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit seg_fits(input int width, input int seg);
        return (width > 0) && (seg > 0) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// ---------------------------------------------------------------------------
// pipe_adder_if
// Operand and result stream bundle for pipe_adder.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf
// Modports:
//   master : operand source / result consumer (drives operands, out_ready)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/adder_seg.sv
// ---------------------------------------------------------------------------
// adder_seg
// Combinational SEG-bit ripple slice.
//   a, b  : segment operands
//   ci    : carry into the slice LSB
//   s     : segment sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (for signed overflow of the top slice)
// ---------------------------------------------------------------------------
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] tot;

    always_comb begin
        tot   = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
        s     = tot[SEG-1:0];
        co    = tot[SEG];
        // The sum bit is a^b^carry-in, so the carry into the MSB falls out directly.
        c_msb = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
    end

endmodule

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
// Pipelined two's-complement adder/subtractor with a valid/ready stream.
// The carry chain is split into SEG-bit slices, one register stage each.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_adder_if.slave (operand stream in, result stream out)
// A beat accepted at edge n is presented on the outputs after edge
// n+STAGES-1. A stalled result (out_valid & ~out_ready) freezes every stage.
// ---------------------------------------------------------------------------
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_adder_if.slave  bus
);

    localparam int STAGES = calc_stages(WIDTH, SEG);

    if (!seg_fits(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    logic              stall;
    logic [STAGES-1:0] vld_p;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic              ovf_p;

    // Subtraction is folded into the operand and carry here; the mode flag
    // goes no further than stage 0.
    assign b_eff = (mode_e'(bus.sub) == SUB) ? ~bus.b : bus.b;
    assign c0    = (mode_e'(bus.sub) == SUB) ? 1'b1   : bus.cin;

    assign stall         = vld_p[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = vld_p[STAGES-1];

    // Valid chain: bubbles shift with the data, nothing is collapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (!stall) begin
            vld_p[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int OP_W  = WIDTH - k * SEG;   // operand bits still to add
        localparam int RES_W = (k + 1) * SEG;     // result bits resolved so far

        logic [OP_W-1:0]  op_a;
        logic [OP_W-1:0]  op_b;
        logic             ci;
        logic [SEG-1:0]   seg_s;
        logic             co;
        logic             c_msb;
        logic [RES_W-1:0] res_nxt;
        logic [RES_W-1:0] res_p;
        logic             co_p;

        if (k == 0) begin : g_src
            assign op_a    = bus.a;
            assign op_b    = b_eff;
            assign ci      = c0;
            assign res_nxt = seg_s;
        end else begin : g_src
            assign op_a    = g_stg[k-1].g_fwd.a_fwd_p;
            assign op_b    = g_stg[k-1].g_fwd.b_fwd_p;
            assign ci      = g_stg[k-1].co_p;
            assign res_nxt = {seg_s, g_stg[k-1].res_p};
        end

        adder_seg #(.SEG(SEG)) u_seg (
            .a     (op_a[SEG-1:0]),
            .b     (op_b[SEG-1:0]),
            .ci    (ci),
            .s     (seg_s),
            .co    (co),
            .c_msb (c_msb)
        );

        // Upper operand slices ride along, one slice consumed per stage.
        if (k < STAGES - 1) begin : g_fwd
            logic [OP_W-SEG-1:0] a_fwd_p;
            logic [OP_W-SEG-1:0] b_fwd_p;

            always_ff @(posedge clk) begin
                if (!stall) begin
                    a_fwd_p <= op_a[OP_W-1:SEG];
                    b_fwd_p <= op_b[OP_W-1:SEG];
                end
            end
        end

        if (k == STAGES - 1) begin : g_reg
            // ---- final stage: visible outputs, cleared on reset ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_p <= '0;
                    co_p  <= 1'b0;
                    ovf_p <= 1'b0;
                end else if (!stall) begin
                    res_p <= res_nxt;
                    co_p  <= co;
                    ovf_p <= co ^ c_msb;
                end
            end
        end else begin : g_reg
            // ---- stage k -> k+1 boundary ----
            always_ff @(posedge clk) begin
                if (!stall) begin
                    res_p <= res_nxt;
                    co_p  <= co;
                end
            end
        end
    end

    assign bus.sum  = g_stg[STAGES-1].res_p;
    assign bus.cout = g_stg[STAGES-1].co_p;
    assign bus.ovf  = ovf_p;

endmodule

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder (WIDTH=16, SEG=4). A behavioural model
// computes each expected result from integer arithmetic; a queue holds the
// results in acceptance order and the cycle each beat entered.
// ---------------------------------------------------------------------------
module tb_pipe_adder;
    import adder_pkg::*;

    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t               q[$];
    int                 n_chk   = 0;
    int                 n_fail  = 0;
    int                 cyc     = 0;
    bit                 lat_en  = 1'b1;
    bit                 use_exp = 1'b0;
    exp_t               drv_exp;
    bit                 stall_prev = 1'b0;
    logic [WIDTH+1:0]   hold_prev;

    // Expected result from plain integer arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint ua, ub, us, sa, sb, ss, smax, smin;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        if (sub) begin
            us     = ua - ub;
            ss     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            us     = ua + ub + longint'(cin);
            ss     = sa + sb + longint'(cin);
            e.cout = (us >= (longint'(1) <<< WIDTH));
        end
        e.sum = us[WIDTH-1:0];
        e.ovf = (ss > smax) || (ss < smin);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                         input logic cin_i, input logic sub_i);
        bus.in_valid = v;
        bus.a        = a_i;
        bus.b        = b_i;
        bus.cin      = cin_i;
        bus.sub      = sub_i;
    endtask

    task automatic idle();
        drive(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One clock: sample at the falling edge (+1), then advance to the next one.
    task automatic tick();
        exp_t e;
        #1;
        check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        if (bus.out_valid && !bus.out_ready) begin
            if (stall_prev) check("stall_hold", {bus.sum, bus.cout, bus.ovf}, hold_prev);
            stall_prev = 1'b1;
            hold_prev  = {bus.sum, bus.cout, bus.ovf};
        end else begin
            stall_prev = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("spurious_valid", bus.out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                check("result", {bus.sum, bus.cout, bus.ovf}, {e.sum, e.cout, e.ovf});
                if (e.lat) check("latency", cyc - e.acc, STAGES);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e     = use_exp ? drv_exp : model(bus.a, bus.b, bus.cin, bus.sub);
            e.acc = cyc;
            e.lat = lat_en;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                        input logic cin_i, input logic sub_i);
        drive(1'b1, a_i, b_i, cin_i, sub_i);
        tick();
        idle();
    endtask

    task automatic send_exp(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                            input logic cin_i, input logic sub_i,
                            input logic [WIDTH-1:0] s_x, input logic co_x, input logic ov_x);
        use_exp      = 1'b1;
        drv_exp.sum  = s_x;
        drv_exp.cout = co_x;
        drv_exp.ovf  = ov_x;
        send(a_i, b_i, cin_i, sub_i);
        use_exp      = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_sum",       bus.sum,       '0);
        check("rst_cout",      bus.cout,      1'b0);
        check("rst_ovf",       bus.ovf,       1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry through every slice.
        send_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain();

        // Subtract with borrow; cin must be ignored in sub mode.
        send_exp(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_exp(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        drain();

        // Signed overflow in both directions.
        send_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();

        // Back-to-back stream at full rate.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, WIDTH'(i * 16'h1111), 16'h0F0F, 1'(i & 1), 1'b0);
            #1;
            check("stream_in_ready", bus.in_ready, 1'b1);
            tick();
        end
        drain();

        // Backpressure with a full pipe.
        lat_en = 1'b0;
        for (int i = 0; i < STAGES; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        check("bp_full_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", bus.in_ready, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        drain();

        // Random traffic with random stalls.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom), 1'($urandom));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with three beats in flight.
        lat_en = 1'b1;
        for (int i = 0; i < 3; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        tick();
        #2;
        check("pre_reset_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_ready", bus.in_ready,  1'b1);
        check("async_rst_sum",   bus.sum,       '0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_exp(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("idle_valid", bus.out_valid, 1'b0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. It succeeds the fixed 4-bit combinational adder. The carry chain is cut into SEG-bit segments, one pipeline stage per segment, so the datapath can run at WIDTH bits and full clock rate. It accepts one operation per cycle and sits between an operand source and a result consumer, either of which may stall.

## Interface
Parameters:
- WIDTH, 16: operand and result width; must be a positive multiple of SEG.
- SEG, 4: bits resolved per pipeline stage; STAGES = WIDTH/SEG.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- Handshake: a beat transfers on in_valid & in_ready. A result transfers on out_valid & out_ready.
- Global stall: stall = out_valid & ~out_ready, and in_ready = ~stall.
  - While stall=1, every stage register holds.
  - Bubbles are not collapsed.
- At accept, operand B is formed as b_eff = sub ? ~b : b and carry c0 = sub ? 1 : cin. Both enter stage 0.
- Stage k (0..STAGES-1) adds segment k of A and b_eff plus the carry registered by stage k-1 (c0 for k=0).
  - It registers the segment result, the carry out, and a per-stage valid bit.
  - Lower result segments travel forward unchanged.
  - Upper operand segments travel forward skewed.
- The final stage also registers the carry into the MSB, for ovf.
- Width rules:
  - sum is truncated to WIDTH bits.
  - cout and ovf are taken only from the last segment.
  - The sub flag is not carried past stage 0; it is folded into b_eff and c0.
- Input values presented while in_valid=0 or stall=1 are don't-care and must not affect outputs.
- Reset (any time, including mid-stream):
  - All per-stage valid bits clear asynchronously, so out_valid=0 and in_ready=1 during reset.
  - sum, cout and ovf reset to 0.
  - In-flight operations are discarded and never emitted.
- out_valid=0 with out_ready=1: pipeline advances and bubbles shift forward.
- out_valid=1 with out_ready=1 and in_valid=1 in the same cycle: the result leaves and a new beat enters (full throughput).

## Timing
- Latency: a beat accepted at edge n yields out_valid=1 with its result after edge n+STAGES-1. Example: STAGES=4 gives 4 cycles from the in-handshake cycle to the out-valid cycle, with no stall.
- Throughput: 1 op/cycle when out_ready is held high.
- Outputs are registered; there is no combinational path from a/b/cin/sub to any output.
- Only one combinational input-to-output path exists: out_ready to in_ready, through one AND gate.
- During stall, sum, cout and ovf are stable. This holds for any number of cycles.
- Release of rst_n: first accept possible on the first rising edge with rst_n=1.

## Structure
- Shared package or header adder_pkg:
  - mode encodings ADD=0 and SUB=1.
  - the function computing STAGES from WIDTH and SEG.
  - an elaboration check that WIDTH % SEG == 0.
- Sub-module adder_seg: a combinational SEG-bit ripple slice.
  - Inputs: a, b, ci.
  - Outputs: s, co, and c_msb (carry into the slice MSB).
  - Instantiated STAGES times via generate. The pipeline registers live in pipe_adder.

## Test plan
All scenarios use WIDTH=16, SEG=4.
- Carry ripple across all segments: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Also drive cin=1 with sub=1 and check the result is unchanged.
- Signed overflow:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0x8000-0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Streaming: 8 back-to-back beats (a=i*0x1111, b=0x0F0F, cin=i&1) with out_ready=1 -> 8 consecutive results in order, in_ready never drops.
- Backpressure: out_ready low for 3 cycles while the pipe is full -> in_ready=0 and sum held stable for all 3 cycles. After release, no beat is lost or duplicated, and results match a golden model.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (asynchronous). After release, none of the 3 beats appears, and a new beat 0x0001+0x0002 yields 0x0003 after 4 cycles.
